// File: rtl/adder_pipelined.sv
// Pipelined N-bit adder/subtractor. The carry chain is split into STAGES chunks,
// with one chunk resolved per register stage, and a valid/ready handshake at both ends.
module adder_pipelined #(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         overflow,
  output logic         zero
);
  localparam int SAFE_STAGES = (STAGES < 1) ? 1 : STAGES;
  localparam int CHUNK       = N / SAFE_STAGES;
  localparam int LAST        = SAFE_STAGES - 1;

  if (STAGES < 1 || (N % SAFE_STAGES) != 0) begin : g_bad_params
    $error("adder_pipelined: STAGES must be >= 1 and must divide N");
  end

  logic adv;

  // The whole pipe moves in lockstep, so a stalled result freezes every stage.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < SAFE_STAGES; k++) begin : g_stage
    localparam int LO   = k * CHUNK;  // first bit resolved by this stage
    localparam int HI_W = N - LO;     // operand bits not yet added on entry

    logic [HI_W-1:0]     a_in;
    logic [HI_W-1:0]     b_in;
    logic                cin_s;
    logic                v_in;
    logic [CHUNK-1:0]    s_chunk;
    logic                c_chunk;
    logic [LO+CHUNK-1:0] sum_n;
    logic                v_q;
    logic                c_q;
    logic [LO+CHUNK-1:0] sum_q;

    if (k == 0) begin : g_src
      // Subtraction is a + ~b + 1, so the forced carry-in replaces c_in.
      assign a_in  = a;
      assign b_in  = sub ? ~b : b;
      assign cin_s = sub | c_in;
      assign v_in  = in_valid;
      assign sum_n = s_chunk;
    end else begin : g_src
      assign a_in  = g_stage[k-1].g_fwd.a_q;
      assign b_in  = g_stage[k-1].g_fwd.b_q;
      assign cin_s = g_stage[k-1].c_q;
      assign v_in  = g_stage[k-1].v_q;
      assign sum_n = {s_chunk, g_stage[k-1].sum_q};
    end

    adder_n #(.W(CHUNK)) u_add (
      .a    (a_in[CHUNK-1:0]),
      .b    (b_in[CHUNK-1:0]),
      .cin  (cin_s),
      .sum  (s_chunk),
      .cout (c_chunk)
    );

    // NOTE: non-blocking assignments, so each stage captures its predecessor's
    // pre-edge value. The datapath is reset as well, so sum and the flags read 0
    // after reset instead of stale data.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (adv) begin
        v_q   <= v_in;
        c_q   <= c_chunk;
        sum_q <= sum_n;
      end
    end

    if (k < LAST) begin : g_fwd
      logic [HI_W-CHUNK-1:0] a_q;
      logic [HI_W-CHUNK-1:0] b_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[HI_W-1:CHUNK];
          b_q <= b_in[HI_W-1:CHUNK];
        end
      end
    end

    if (k == LAST) begin : g_last
      logic ovf_q;
      logic zero_q;

      // At this point a_in and b_in hold the top chunk, so bit HI_W-1 is the sign bit.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv) begin
          ovf_q  <= (a_in[HI_W-1] == b_in[HI_W-1]) && (sum_n[N-1] != a_in[HI_W-1]);
          zero_q <= (sum_n == '0);
        end
      end
    end
  end

  assign out_valid = g_stage[LAST].v_q;
  assign sum       = g_stage[LAST].sum_q;
  assign c_out     = g_stage[LAST].c_q;
  assign overflow  = g_stage[LAST].g_last.ovf_q;
  assign zero      = g_stage[LAST].g_last.zero_q;

endmodule

// W-bit ripple adder with carry in and carry out; one instance per pipeline chunk.
module adder_n #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

// File: tb/tb_adder_pipelined.sv
// Scoreboard bench for adder_pipelined. It drives STAGES=4, 1 and 32 instances
// from one stimulus stream, with a separate expected-result queue per instance.
module tb_adder_pipelined;
  localparam int N  = 32;
  localparam int ND = 3;
  localparam longint MAX_S = (longint'(1) <<< (N-1)) - 1;
  localparam longint MIN_S = -(longint'(1) <<< (N-1));

  typedef struct packed {
    logic [N-1:0] sum;
    logic         c_out;
    logic         overflow;
    logic         zero;
  } res_t;

  logic         clk = 1'b0;
  logic         rst, in_valid, c_in, sub, out_ready;
  logic [N-1:0] a, b;
  logic         in_ready  [ND];
  logic         out_valid [ND];
  logic [N-1:0] sum       [ND];
  logic         c_out     [ND];
  logic         overflow  [ND];
  logic         zero      [ND];

  int   vectors     = 0;
  int   miscompares = 0;
  res_t sb [ND][$];
  int   run  [ND];
  int   best [ND];
  bit   rand_ready = 1'b0;

  always #5 clk = ~clk;

  adder_pipelined #(.N(N), .STAGES(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
    .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid[0]),
    .out_ready(out_ready), .sum(sum[0]), .c_out(c_out[0]),
    .overflow(overflow[0]), .zero(zero[0])
  );

  adder_pipelined #(.N(N), .STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
    .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid[1]),
    .out_ready(out_ready), .sum(sum[1]), .c_out(c_out[1]),
    .overflow(overflow[1]), .zero(zero[1])
  );

  adder_pipelined #(.N(N), .STAGES(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]),
    .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid[2]),
    .out_ready(out_ready), .sum(sum[2]), .c_out(c_out[2]),
    .overflow(overflow[2]), .zero(zero[2])
  );

  // Reference model: unsigned compare gives the borrow, signed range gives overflow.
  function automatic res_t model(input logic [N-1:0] x, input logic [N-1:0] y,
                                 input logic ci, input logic s);
    res_t         r;
    longint       sx, sy, sr;
    logic [N:0]   full;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (s) begin
      r.sum   = x - y;
      r.c_out = (x >= y);
      sr      = sx - sy;
    end else begin
      full    = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, ci};
      r.sum   = full[N-1:0];
      r.c_out = full[N];
      sr      = sx + sy + longint'(ci);
    end
    r.overflow = (sr > MAX_S) || (sr < MIN_S);
    r.zero     = (r.sum == '0);
    return r;
  endfunction

  // Transfers are decided at the negedge, where inputs and outputs are stable
  // until the next rising edge.
  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (rst) begin
        sb[d].delete();
        run[d] = 0;
      end else begin
        if (out_valid[d] && out_ready) begin
          res_t got, exp;
          got = {sum[d], c_out[d], overflow[d], zero[d]};
          vectors++;
          if (sb[d].size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_result dut%0d: got sum=%h c=%b v=%b z=%b, required no output",
                     d, got.sum, got.c_out, got.overflow, got.zero);
          end else begin
            exp = sb[d].pop_front();
            if (got !== exp)
              begin
                miscompares++;
                $display("FAIL result dut%0d: got sum=%h c=%b v=%b z=%b, required sum=%h c=%b v=%b z=%b",
                         d, got.sum, got.c_out, got.overflow, got.zero,
                         exp.sum, exp.c_out, exp.overflow, exp.zero);
              end
          end
          run[d]++;
          if (run[d] > best[d]) best[d] = run[d];
        end else begin
          run[d] = 0;
        end
        if (in_valid && in_ready[d]) sb[d].push_back(model(a, b, c_in, sub));
      end
    end
  end

  task automatic send(input logic [N-1:0] x, input logic [N-1:0] y,
                      input logic ci, input logic s);
    bit accepted = 1'b0;
    int budget   = 60;
    a = x; b = y; c_in = ci; sub = s; in_valid = 1'b1;
    while (!accepted && budget > 0) begin
      @(negedge clk);
      accepted = in_ready[0];
      @(posedge clk);
      #1;
      budget--;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
    if (!accepted) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1 within 60 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 100;
    out_ready = 1'b1;
    while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    if (budget == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d/%0d/%0d results outstanding, required 0",
               sb[0].size(), sb[1].size(), sb[2].size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      vectors++;
      if ({out_valid[d], sum[d], c_out[d], overflow[d], zero[d], in_ready[d]} !==
          {1'b0, {N{1'b0}}, 3'b000, 1'b1}) begin
        miscompares++;
        $display("FAIL reset_state dut%0d: got ov=%b sum=%h c=%b v=%b z=%b ir=%b, required 0/0/0/0/0/1",
                 d, out_valid[d], sum[d], c_out[d], overflow[d], zero[d], in_ready[d]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    out_ready = 1'b1;
    send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    send(32'h5, 32'h7, 1'b0, 1'b1);
    send(32'h7, 32'h5, 1'b1, 1'b1);
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    send(32'h8000_0000, 32'h1, 1'b0, 1'b1);
    send(32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0);
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_latency();
    out_ready = 1'b0;
    send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    vectors++;
    if (out_valid[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL latency_stages1: out_valid=%b one edge after accept, required 1", out_valid[1]);
    end
    for (int e = 0; e < 4; e++) begin
      vectors++;
      if (out_valid[0] !== (e == 3)) begin
        miscompares++;
        $display("FAIL latency_stages4: out_valid=%b %0d edges after accept, required %b",
                 out_valid[0], e + 1, (e == 3));
      end
      if (e < 3) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int d = 0; d < ND; d++) best[d] = 0;
    for (int i = 0; i < 8; i++) send(N'(i), N'(i * 3), 1'b0, 1'b0);
    drain();
    for (int d = 0; d < ND; d++) begin
      vectors++;
      if (best[d] != 8) begin
        miscompares++;
        $display("FAIL back_to_back_run dut%0d: longest out_valid run %0d, required 8", d, best[d]);
      end
    end
  endtask

  task automatic test_stall();
    res_t snap;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(N'(100 + i), N'(i), 1'b1, 1'b0);
    a = 32'h1234_5678; b = 32'h0000_0001; c_in = 1'b0; sub = 1'b1;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    snap = {sum[0], c_out[0], overflow[0], zero[0]};
    vectors++;
    if (out_valid[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_valid: out_valid=%b while stalled, required 1", out_valid[0]);
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      vectors++;
      if ({out_valid[0], sum[0], c_out[0], overflow[0], zero[0], in_ready[0]} !==
          {1'b1, snap, 1'b0}) begin
        miscompares++;
        $display("FAIL stall_hold cycle%0d: got ov=%b sum=%h ir=%b, required ov=1 sum=%h ir=0",
                 c, out_valid[0], sum[0], in_ready[0], snap.sum);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    send(32'h1234_5678, 32'h0000_0001, 1'b0, 1'b1);
    send(32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(N'(7 + i), N'(9), 1'b0, 1'b0);
    a = 32'hAAAA_0000; b = 32'h5555; in_valid = 1'b1;
    rst = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      vectors++;
      if ({out_valid[d], sum[d], in_ready[d]} !== {1'b0, {N{1'b0}}, 1'b1}) begin
        miscompares++;
        $display("FAIL reset_midstream dut%0d: got ov=%b sum=%h ir=%b, required ov=0 sum=0 ir=1",
                 d, out_valid[d], sum[d], in_ready[d]);
      end
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++)
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    rand_ready = 1'b0;
    drain();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b0;
    for (int d = 0; d < ND; d++) begin
      run[d]  = 0;
      best[d] = 0;
    end
    test_reset();
    test_directed();
    test_latency();
    test_back_to_back();
    test_stall();
    test_reset_midstream();
    test_directed();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
